// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 streaming controller and the MD5 core:
// controller states, block geometry, padding constant and initial chaining value.
package md5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEWTEXT,
        ST_COLLECT,
        ST_PAD,
        ST_LOAD,
        ST_WAIT,
        ST_EXTRA
    } state_t;

    localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
    localparam int         BLOCK_WORDS  = 16;
    localparam int         BEATS        = 4;

    // Initial chaining value {A,B,C,D}
    localparam logic [127:0] MD5_IV = {32'h67452301, 32'hefcdab89,
                                       32'h98badcfe, 32'h10325476};

    // Keeps the first nbytes bytes, places the pad marker after them, clears the rest.
    function automatic logic [31:0] pad_word(input logic [31:0] word,
                                             input logic [2:0]  nbytes);
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes)) begin
                res[8*k +: 8] = word[8*k +: 8];
            end else if (k == int'(nbytes)) begin
                res[8*k +: 8] = MD5_PAD_BYTE;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/md5_pad_fill.sv
// Combinational MD5 padding of one 512-bit block: marker byte, zero fill, bit length.
// In extra mode it builds the length-only block that follows an overflowing final block.
module md5_pad_fill
    import md5_pkg::*;
(
    input  logic [511:0] block_in,
    input  logic [4:0]   last_idx,
    input  logic [2:0]   nbytes,
    input  logic [63:0]  bit_len,
    input  logic         extra_mode,
    output logic [511:0] block_out,
    output logic         final_blk
);

    logic [4:0] pad_idx;

    // A full last word pushes the marker into the next word, possibly past the block
    always_comb begin
        pad_idx = (nbytes < 3'd4) ? last_idx : last_idx + 5'd1;
    end

    always_comb begin
        block_out = '0;
        final_blk = 1'b0;
        if (extra_mode) begin
            if (pad_idx == 5'd16) begin
                block_out[511 -: 32] = {24'h0, MD5_PAD_BYTE};
            end
            final_blk = 1'b1;
        end else begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                if (5'(w) < last_idx) begin
                    block_out[511-32*w -: 32] = block_in[511-32*w -: 32];
                end else if (5'(w) == last_idx) begin
                    block_out[511-32*w -: 32] = pad_word(block_in[511-32*w -: 32], nbytes);
                end else if (5'(w) == pad_idx) begin
                    block_out[511-32*w -: 32] = {24'h0, MD5_PAD_BYTE};
                end
            end
            final_blk = (pad_idx <= 5'd13);
        end
        // Words 14/15 carry the low/high halves of the bit length
        if (final_blk) begin
            block_out[63:32] = bit_len[31:0];
            block_out[31:0]  = bit_len[63:32];
        end
    end

endmodule

// File: rtl/md5_stream_ctrl.sv
// Streams 32-bit message words into 512-bit blocks, pads them, feeds the MD5 core
// in four 128-bit beats per block and strobes out the final digest.
module md5_stream_ctrl
    import md5_pkg::*;
#(
    parameter int LEN_W = 32
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [31:0]  in_data_i,
    input  logic         in_last_i,
    input  logic [2:0]   in_nbytes_i,
    output logic         core_newtext_o,
    output logic         core_load_o,
    output logic [127:0] core_data_o,
    input  logic         core_ready_i,
    input  logic [127:0] core_data_i,
    output logic         busy_o,
    output logic [127:0] digest_o,
    output logic         digest_valid_o
);

    state_t           state;
    state_t           state_next;
    logic [31:0]      words [BLOCK_WORDS];
    logic [511:0]     block_flat;
    logic [511:0]     padded;
    logic             pad_final;
    logic [4:0]       word_idx;
    logic [4:0]       last_idx;
    logic [2:0]       last_nbytes;
    logic [LEN_W-1:0] byte_cnt;
    logic [63:0]      bit_len;
    logic [1:0]       beat;
    logic             more;
    logic             final_flag;
    logic             accept;

    always_comb begin
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            block_flat[511-32*w -: 32] = words[w];
        end
    end

    assign bit_len = 64'({byte_cnt, 3'b000});
    assign accept  = (state == ST_COLLECT) && (word_idx < 5'd16) && in_valid_i;

    md5_pad_fill u_pad_fill (
        .block_in   (block_flat),
        .last_idx   (last_idx),
        .nbytes     (last_nbytes),
        .bit_len    (bit_len),
        .extra_mode (state == ST_EXTRA),
        .block_out  (padded),
        .final_blk  (pad_final)
    );

    always_comb begin
        state_next     = state;
        in_ready_o     = 1'b0;
        core_newtext_o = 1'b0;
        core_load_o    = 1'b0;
        core_data_o    = '0;
        busy_o         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_next = ST_NEWTEXT;
                end
            end
            ST_NEWTEXT: begin
                core_newtext_o = 1'b1;
                state_next     = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready_o = (word_idx < 5'd16);
                if (accept) begin
                    if (in_last_i) begin
                        state_next = ST_PAD;
                    end else if (word_idx == 5'd15) begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_PAD: begin
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                core_load_o = 1'b1;
                core_data_o = {words[{beat, 2'd0}], words[{beat, 2'd1}],
                               words[{beat, 2'd2}], words[{beat, 2'd3}]};
                if (beat == 2'(BEATS - 1)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_ready_i) begin
                    if (more) begin
                        state_next = ST_COLLECT;
                    end else if (final_flag) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_EXTRA;
                    end
                end
            end
            ST_EXTRA: begin
                state_next = ST_LOAD;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            word_idx       <= '0;
            last_idx       <= '0;
            last_nbytes    <= '0;
            byte_cnt       <= '0;
            beat           <= '0;
            more           <= 1'b0;
            final_flag     <= 1'b0;
            digest_o       <= '0;
            digest_valid_o <= 1'b0;
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                words[w] <= '0;
            end
        end else begin
            state          <= state_next;
            digest_valid_o <= 1'b0;
            case (state)
                ST_NEWTEXT: begin
                    byte_cnt   <= '0;
                    word_idx   <= '0;
                    more       <= 1'b0;
                    final_flag <= 1'b0;
                end
                ST_COLLECT: begin
                    if (accept) begin
                        words[word_idx[3:0]] <= in_data_i;
                        word_idx             <= word_idx + 5'd1;
                        more                 <= !in_last_i && (word_idx == 5'd15);
                        if (in_last_i) begin
                            byte_cnt    <= byte_cnt + LEN_W'(in_nbytes_i);
                            last_idx    <= word_idx;
                            last_nbytes <= in_nbytes_i;
                        end else begin
                            byte_cnt <= byte_cnt + LEN_W'(4);
                        end
                    end
                end
                ST_PAD, ST_EXTRA: begin
                    final_flag <= pad_final;
                    for (int w = 0; w < BLOCK_WORDS; w++) begin
                        words[w] <= padded[511-32*w -: 32];
                    end
                end
                ST_LOAD: begin
                    beat <= beat + 2'd1;
                end
                ST_WAIT: begin
                    // A full intermediate block resumes collection into a fresh buffer
                    if (core_ready_i) begin
                        if (more) begin
                            word_idx <= '0;
                            more     <= 1'b0;
                        end else if (final_flag) begin
                            digest_o       <= core_data_i;
                            digest_valid_o <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_stream_ctrl.sv
// Scoreboard bench for md5_stream_ctrl with a behavioural MD5 core and a software reference digest.
module tb_md5_stream_ctrl;

    localparam logic [127:0] IV        = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [127:0] ABC_DIG   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [127:0] EMPTY_DIG = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    typedef struct {
        logic [127:0] dig;
        int           nblk;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         core_newtext;
    logic         core_load;
    logic [127:0] core_data_out;
    logic         mdl_ready;
    logic [127:0] mdl_chain;
    logic         busy;
    logic [127:0] digest;
    logic         digest_valid;

    logic [511:0] mdl_blk;
    int           mdl_beat;
    int           mdl_wait;
    logic         mdl_busy;
    int           mdl_err;
    int           core_delay;

    exp_t         sb_q[$];
    logic [7:0]   msg_q[$];
    int           total;
    int           bad;
    int           mon_err;
    bit           abort;

    md5_stream_ctrl #(.LEN_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .in_nbytes_i    (in_nbytes),
        .core_newtext_o (core_newtext),
        .core_load_o    (core_load),
        .core_data_o    (core_data_out),
        .core_ready_i   (mdl_ready),
        .core_data_i    (mdl_chain),
        .busy_o         (busy),
        .digest_o       (digest),
        .digest_valid_o (digest_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [127:0] md5Compress(input logic [127:0] st, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f;
        int g;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            f = f + a + K_TAB[i] + blk[511-32*g -: 32];
            a = d; d = c; c = b;
            b = b + rotl(f, S_TAB[(i/16)*4 + i%4]);
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    // Byte-oriented textbook padding, independent of the block-level padding in the design
    function automatic logic [127:0] refDigest();
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [127:0] st;
        logic [511:0] blk;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg_q.size()) * 64'd8;
        for (int k = 0; k < 8; k++) p.push_back(bl[8*k +: 8]);
        st = IV;
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int i = 0; i < 16; i++) begin
                blk[511-32*i -: 32] = {p[64*bk+4*i+3], p[64*bk+4*i+2], p[64*bk+4*i+1], p[64*bk+4*i]};
            end
            st = md5Compress(st, blk);
        end
        return st;
    endfunction

    // Behavioural MD5 core: collects four beats, compresses after core_delay cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_ready <= 1'b1;
            mdl_chain <= IV;
            mdl_blk   <= '0;
            mdl_beat  <= 0;
            mdl_wait  <= 0;
            mdl_busy  <= 1'b0;
            mdl_err   <= 0;
        end else begin
            if (core_newtext) begin
                mdl_chain <= IV;
                mdl_beat  <= 0;
            end
            if (core_load) begin
                if (mdl_busy) mdl_err <= mdl_err + 1;
                mdl_ready <= 1'b0;
                case (mdl_beat)
                    0: mdl_blk[511:384] <= core_data_out;
                    1: mdl_blk[383:256] <= core_data_out;
                    2: mdl_blk[255:128] <= core_data_out;
                    default: mdl_blk[127:0] <= core_data_out;
                endcase
                if (mdl_beat >= 3) begin
                    mdl_busy <= 1'b1;
                    mdl_wait <= core_delay;
                    mdl_beat <= 0;
                end else begin
                    mdl_beat <= mdl_beat + 1;
                end
            end else if (mdl_busy) begin
                if (mdl_wait == 0) begin
                    mdl_chain <= md5Compress(mdl_chain, mdl_blk);
                    mdl_ready <= 1'b1;
                    mdl_busy  <= 1'b0;
                end else begin
                    mdl_wait <= mdl_wait - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 128'({in_ready, core_newtext, core_load, busy, digest_valid}), 128'(0));
        checkOutput({tag, "_core_data"}, core_data_out, 128'(0));
        checkOutput({tag, "_digest"}, digest, 128'(0));
    endtask

    task automatic fillMessage(input int n, input int seed);
        msg_q.delete();
        for (int k = 0; k < n; k++) msg_q.push_back(8'((k*13 + seed*7 + 5) & 255));
    endtask

    task automatic applyStimulus(input bit gaps, input bit use_hand, input logic [127:0] hand_dig);
        exp_t e;
        int   n, nwords, nb, cyc;
        bit   accepted, take, last;
        logic [31:0] data;
        n      = msg_q.size();
        e.dig  = use_hand ? hand_dig : refDigest();
        e.nblk = (n + 8) / 64 + 1;
        sb_q.push_back(e);
        nwords = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nwords && !abort; w++) begin
            data = '0;
            for (int k = 0; k < 4; k++) if (4*w + k < n) data[8*k +: 8] = msg_q[4*w + k];
            last     = (w == nwords - 1);
            nb       = last ? n - 4*w : 4;
            accepted = 1'b0;
            cyc      = 0;
            while (!accepted && !abort) begin
                @(negedge clk);
                in_data   = data;
                in_last   = last;
                in_nbytes = 3'(nb);
                in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                take      = in_valid && in_ready;
                @(posedge clk);
                if (take) begin
                    accepted = 1'b1;
                end else if (++cyc > 3000) begin
                    total++; bad++; abort = 1'b1;
                    $display("[TB] FAIL word_accept: got no in_ready_o expected acceptance of word %0d", w);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drain", 128'(sb_q.size()), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every digest strobe and watches handshake rules
    initial begin
        int   nt_cnt, ld_cnt;
        bit   prev_valid;
        exp_t e;
        nt_cnt = 0; ld_cnt = 0; prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nt_cnt = 0; ld_cnt = 0; prev_valid = 1'b0;
            end else begin
                if (core_newtext && core_load) mon_err++;
                if ((core_load || mdl_busy) && in_ready) mon_err++;
                if (core_newtext) nt_cnt++;
                if (core_load) ld_cnt++;
                if (prev_valid) checkOutput("valid_pulse", 128'(digest_valid), 128'(0));
                if (digest_valid) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("[TB] FAIL unexpected_digest: got %h expected no digest", digest);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("digest", digest, e.dig);
                        checkOutput("load_beats", 128'(ld_cnt), 128'(4 * e.nblk));
                        checkOutput("newtext_count", 128'(nt_cnt), 128'(1));
                    end
                    nt_cnt = 0; ld_cnt = 0;
                end
                prev_valid = digest_valid;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        total++; bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int cyc;
        bit found;
        clk = 1'b0; reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
        core_delay = 3; total = 0; bad = 0; mon_err = 0; abort = 1'b0;
        #2 reset = 1'b0;
        #1 checkResetOutputs("reset_init");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        $display("[TB] abc and empty message");
        msg_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b0, 1'b1, ABC_DIG);
        waitDrain();
        msg_q.delete();
        applyStimulus(1'b0, 1'b1, EMPTY_DIG);
        waitDrain();

        $display("[TB] 55/56/64-byte boundary messages");
        fillMessage(55, 1); applyStimulus(1'b0, 1'b0, '0);
        fillMessage(56, 2); applyStimulus(1'b0, 1'b0, '0);
        fillMessage(64, 3); applyStimulus(1'b0, 1'b0, '0);
        waitDrain();

        $display("[TB] 130-byte message with gaps, back-to-back traffic");
        fillMessage(130, 4); applyStimulus(1'b1, 1'b0, '0);
        fillMessage(10, 5);  applyStimulus(1'b1, 1'b0, '0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b0, 1'b1, ABC_DIG);
        waitDrain();

        $display("[TB] reset while waiting on block 2");
        core_delay = 30;
        fillMessage(100, 6); applyStimulus(1'b0, 1'b0, '0);
        found = 1'b0; cyc = 0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (busy && !core_load && !mdl_ready) found = 1'b1;
        end
        checkOutput("reached_wait", 128'(found), 128'(1));
        reset = 1'b0;
        #1 checkResetOutputs("reset_mid");
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        core_delay = 3;
        msg_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus(1'b0, 1'b1, ABC_DIG);
        waitDrain();

        $display("[TB] stretched core latency");
        core_delay = 200;
        fillMessage(20, 7); applyStimulus(1'b0, 1'b0, '0);
        waitDrain();
        core_delay = 3;

        checkOutput("core_protocol", 128'(mdl_err), 128'(0));
        checkOutput("stream_protocol", 128'(mon_err), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
